// File: rtl/spi_acl2_pkg.sv
// spi_acl2_pkg: opcodes, command encoding and FSM states for the ACL2 SPI master
package spi_acl2_pkg;
    localparam logic [7:0] OPC_WRITE = 8'h0A;
    localparam logic [7:0] OPC_READ  = 8'h0B;
    localparam logic [7:0] OPC_FIFO  = 8'h0D;
    typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_READ = 2'b01, OP_FIFO = 2'b10, OP_RSVD = 2'b11} cmd_op_t;
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;
    function automatic logic [7:0] opcode(input cmd_op_t op);
        return op == OP_WRITE ? OPC_WRITE : op == OP_READ ? OPC_READ : OPC_FIFO;
    endfunction
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SCLK half-period divider with rise/fall enables, held low while disabled
module spi_sclk_gen #(
    parameter int CLK_DIV = 1221
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic SCLK,
    output logic RISE,
    output logic FALL
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] cnt;
    logic last;
    assign last = cnt == CW'(CLK_DIV - 1);
    assign RISE = EN && SCLK && cnt == '0;
    assign FALL = EN && SCLK && last;
    always_ff @(posedge CLK) begin
        if (RST || !EN) begin
            cnt  <= '0;
            SCLK <= 1'b0;
        end else if (last) begin
            cnt  <= '0;
            SCLK <= ~SCLK;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_acl2_master.sv
// spi_acl2_master: SPI mode-0 master for the ADXL362; define ACL2_MISO_SYNC_EN to synchronise MISO (CLK_DIV >= 4)
module spi_acl2_master import spi_acl2_pkg::*; #(
    parameter int CLK_DIV        = 1221,
    parameter int MAX_BURST      = 16,
    parameter int CS_IDLE_CYCLES = 4
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           CMD_VALID,
    output logic                           CMD_READY,
    input  logic [1:0]                     CMD_OP,
    input  logic [7:0]                     CMD_ADDR,
    input  logic [$clog2(MAX_BURST+1)-1:0] CMD_LEN,
    input  logic [7:0]                     CMD_WDATA,
    output logic [7:0]                     RDATA,
    output logic                           RDATA_VALID,
    output logic                           BUSY,
    output logic                           DONE,
    input  logic                           MISO,
    output logic                           CS,
    output logic                           SCLK,
    output logic                           MOSI
);
    localparam int LW = $clog2(MAX_BURST + 1);
    localparam int BW = $clog2(MAX_BURST + 3);
    localparam int TMAX = CLK_DIV > CS_IDLE_CYCLES ? CLK_DIV : CS_IDLE_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    state_t state;
    cmd_op_t op, cop;
    logic [7:0] addr, wdata, tx, rx, first_byte, next_byte;
    logic [LW-1:0] len, len_c;
    logic [BW-1:0] byte_cnt, nb, start_cnt;
    logic [2:0] bit_cnt;
    logic [TW-1:0] tmr;
    logic miso_s, rise, fall;
`ifdef ACL2_MISO_SYNC_EN
    logic [1:0] miso_q;
    always_ff @(posedge CLK) miso_q <= {miso_q[0], MISO};
    assign miso_s = miso_q[1];
`else
    assign miso_s = MISO;
`endif
    assign cop = cmd_op_t'(CMD_OP);
    assign CMD_READY = state == IDLE;
    assign BUSY = state != IDLE;
    assign len_c = CMD_LEN == '0 ? LW'(1) : CMD_LEN > LW'(MAX_BURST) ? LW'(MAX_BURST) : CMD_LEN;
    assign first_byte = opcode(cop);
    // byte_cnt counts bytes still to send after the current one
    assign start_cnt = cop == OP_WRITE ? BW'(2) : cop == OP_READ ? BW'(len_c) + BW'(1) : BW'(len_c);
    assign nb = byte_cnt - 1'b1;
    assign next_byte = op == OP_WRITE ? (nb == BW'(1) ? addr : wdata) :
                       (op == OP_READ && nb == BW'(len)) ? addr : 8'h00;
    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .CLK(CLK), .RST(RST), .EN(state == SHIFT), .SCLK(SCLK), .RISE(rise), .FALL(fall)
    );
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            CS          <= 1'b1;
            MOSI        <= 1'b0;
            RDATA       <= 8'h00;
            RDATA_VALID <= 1'b0;
            DONE        <= 1'b0;
            tmr         <= '0;
        end else begin
            RDATA_VALID <= 1'b0;
            DONE        <= 1'b0;
            case (state)
                IDLE: if (CMD_VALID) begin
                    op      <= cop;
                    addr    <= CMD_ADDR;
                    wdata   <= CMD_WDATA;
                    len     <= len_c;
                    bit_cnt <= 3'd7;
                    tmr     <= '0;
                    if (cop == OP_RSVD) begin
                        DONE <= 1'b1;
                    end else begin
                        state    <= SHIFT;
                        CS       <= 1'b0;
                        tx       <= first_byte;
                        MOSI     <= first_byte[7];
                        byte_cnt <= start_cnt;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        rx <= {rx[6:0], miso_s};
                        if (bit_cnt == 3'd0 && op != OP_WRITE && byte_cnt < BW'(len)) begin
                            RDATA       <= {rx[6:0], miso_s};
                            RDATA_VALID <= 1'b1;
                        end
                    end
                    if (fall) begin
                        if (bit_cnt != 3'd0) begin
                            bit_cnt <= bit_cnt - 1'b1;
                            tx      <= {tx[6:0], 1'b0};
                            MOSI    <= tx[6];
                        end else if (byte_cnt == '0) begin
                            state <= HOLD;
                            MOSI  <= 1'b0;
                        end else begin
                            bit_cnt  <= 3'd7;
                            byte_cnt <= nb;
                            tx       <= next_byte;
                            MOSI     <= next_byte[7];
                        end
                    end
                end
                HOLD: if (tmr == TW'(CLK_DIV - 1)) begin
                    tmr   <= '0;
                    state <= GAP;
                    CS    <= 1'b1;
                    DONE  <= 1'b1;
                end else begin
                    tmr <= tmr + 1'b1;
                end
                // the IDLE/accept cycle is the last CS-high cycle of the gap
                GAP: if (int'(tmr) >= CS_IDLE_CYCLES - 2) state <= IDLE;
                     else tmr <= tmr + 1'b1;
            endcase
        end
    end
endmodule
